// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX arbiter: AXI-Stream widths, arbiter
// state encoding and the winner-selection helper.
package eth_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_PKT  = 2'b01,
        ARB_GAP  = 2'b10
    } arb_state_e;

    // Winner for a new frame; ties go to port 1 in fixed mode, else away from the last owner.
    function automatic logic arb_pick(
        input logic v0,
        input logic v1,
        input logic last_grant,
        input logic prio_fixed
    );
        logic win;
        win = 1'b0;
        if (v0 && v1) begin
            win = prio_fixed ? 1'b1 : ~last_grant;
        end else if (v1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/eth_tx_arb_sel.sv
// Combinational 2:1 AXI-Stream mux with tready steering. Only the granted
// source sees the MAC's tready, and output payload is zero whenever tvalid is low.
module eth_tx_arb_sel
    import eth_pkg::*;
(
    input  logic                   grant,
    input  logic                   pass_en,
    input  logic                   s0_axis_tvalid,
    input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
    input  logic                   s0_axis_tlast,
    input  logic                   s0_axis_tuser,
    output logic                   s0_axis_tready,
    input  logic                   s1_axis_tvalid,
    input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
    input  logic                   s1_axis_tlast,
    input  logic                   s1_axis_tuser,
    output logic                   s1_axis_tready,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser
);

    // Route the granted source to the MAC while a frame is open.
    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = {AXIS_DATA_W{1'b0}};
        m_axis_tkeep   = {AXIS_KEEP_W{1'b0}};
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (pass_en) begin
            if (grant) begin
                m_axis_tvalid  = s1_axis_tvalid;
                s1_axis_tready = m_axis_tready;
                if (s1_axis_tvalid) begin
                    m_axis_tdata = s1_axis_tdata;
                    m_axis_tkeep = s1_axis_tkeep;
                    m_axis_tlast = s1_axis_tlast;
                    m_axis_tuser = s1_axis_tuser;
                end else begin
                    m_axis_tdata = {AXIS_DATA_W{1'b0}};
                end
            end else begin
                m_axis_tvalid  = s0_axis_tvalid;
                s0_axis_tready = m_axis_tready;
                if (s0_axis_tvalid) begin
                    m_axis_tdata = s0_axis_tdata;
                    m_axis_tkeep = s0_axis_tkeep;
                    m_axis_tlast = s0_axis_tlast;
                    m_axis_tuser = s0_axis_tuser;
                end else begin
                    m_axis_tdata = {AXIS_DATA_W{1'b0}};
                end
            end
        end else begin
            m_axis_tvalid = 1'b0;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular 2:1 arbiter in front of the 10G MAC TX stream, with optional
// post-frame idle gap. Define ETH_TX_ARB_STATS_EN to add per-port frame/error counters.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int PRIO_MODE  = 0,
    parameter int GAP_W      = 16
) (
    input  logic                   clk156,
    input  logic                   eth_rst,
    output logic [7:0]             debug,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
    input  logic                   s0_axis_tlast,
    input  logic                   s0_axis_tuser,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
    input  logic                   s1_axis_tlast,
    input  logic                   s1_axis_tuser,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [31:0]            stat_frames0,
    output logic [31:0]            stat_frames1,
    output logic [15:0]            stat_err
`endif
);

    localparam logic             HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic             PRIO_FIXED = (PRIO_MODE != 0);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

    arb_state_e       state_r, state_s;
    logic             grant_r, grant_s;
    logic             last_grant_r, last_grant_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic [3:0]       frame_cnt_r, frame_cnt_s;
    logic             pass_en_s;
    logic             xfer_last_s;

    assign pass_en_s   = (state_r == ARB_PKT);
    assign xfer_last_s = pass_en_s && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    eth_tx_arb_sel u_sel (
        .grant          (grant_r),
        .pass_en        (pass_en_s),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser)
    );

    // Next-state logic: arbitrate in IDLE, hold grant for a whole frame, then pace.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        gap_cnt_s    = gap_cnt_r;
        frame_cnt_s  = frame_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    grant_s = arb_pick(s0_axis_tvalid, s1_axis_tvalid, last_grant_r, PRIO_FIXED);
                    state_s = ARB_PKT;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_PKT: begin
                if (xfer_last_s) begin
                    last_grant_s = grant_r;
                    frame_cnt_s  = frame_cnt_r + 4'd1;
                    state_s      = HAS_GAP ? ARB_GAP : ARB_IDLE;
                end else begin
                    state_s = ARB_PKT;
                end
            end
            ARB_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    state_s   = ARB_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end
            default: begin
                state_s   = ARB_IDLE;
                gap_cnt_s = {GAP_W{1'b0}};
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state_r      <= ARB_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            gap_cnt_r    <= {GAP_W{1'b0}};
            frame_cnt_r  <= 4'd0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            gap_cnt_r    <= gap_cnt_s;
            frame_cnt_r  <= frame_cnt_s;
        end
    end

    // Debug is forced low while reset is held so it reads all-zero like every other output.
    assign debug = eth_rst ? 8'h00 : {state_r, grant_r, last_grant_r, frame_cnt_r};

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] stat_frames0_r;
    logic [31:0] stat_frames1_r;
    logic [15:0] stat_err_r;

    // Completed-frame counters per port; the error counter saturates instead of wrapping.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            stat_frames0_r <= 32'd0;
            stat_frames1_r <= 32'd0;
            stat_err_r     <= 16'd0;
        end else begin
            if (xfer_last_s && !grant_r) begin
                stat_frames0_r <= stat_frames0_r + 32'd1;
            end
            if (xfer_last_s && grant_r) begin
                stat_frames1_r <= stat_frames1_r + 32'd1;
            end
            if (xfer_last_s && m_axis_tuser && (stat_err_r != 16'hffff)) begin
                stat_err_r <= stat_err_r + 16'd1;
            end
        end
    end

    assign stat_frames0 = stat_frames0_r;
    assign stat_frames1 = stat_frames1_r;
    assign stat_err     = stat_err_r;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: three instances (RR, fixed priority,
// GAP_CYCLES=12) share stimulus and are each compared against a frame-level model.
module tb_eth_tx_arbiter;

    logic        clk156 = 1'b0;
    logic        eth_rst = 1'b1;
    logic        s_v [2];
    logic [63:0] s_d [2];
    logic [7:0]  s_k [2];
    logic        s_l [2];
    logic        s_u [2];
    logic        m_ready;

    logic        o_mv  [3];
    logic [63:0] o_md  [3];
    logic [7:0]  o_mk  [3];
    logic        o_ml  [3];
    logic        o_mu  [3];
    logic        o_r0  [3];
    logic        o_r1  [3];
    logic [7:0]  o_dbg [3];
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] o_f0  [3];
    logic [31:0] o_f1  [3];
    logic [15:0] o_err [3];
`endif

    always #5 clk156 = ~clk156;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        eth_tx_arbiter #(
            .GAP_CYCLES (g == 2 ? 12 : 0),
            .PRIO_MODE  (g == 1 ? 1 : 0),
            .GAP_W      (16)
        ) u_dut (
            .clk156         (clk156),
            .eth_rst        (eth_rst),
            .debug          (o_dbg[g]),
            .s0_axis_tvalid (s_v[0]),
            .s0_axis_tready (o_r0[g]),
            .s0_axis_tdata  (s_d[0]),
            .s0_axis_tkeep  (s_k[0]),
            .s0_axis_tlast  (s_l[0]),
            .s0_axis_tuser  (s_u[0]),
            .s1_axis_tvalid (s_v[1]),
            .s1_axis_tready (o_r1[g]),
            .s1_axis_tdata  (s_d[1]),
            .s1_axis_tkeep  (s_k[1]),
            .s1_axis_tlast  (s_l[1]),
            .s1_axis_tuser  (s_u[1]),
            .m_axis_tready  (m_ready),
            .m_axis_tvalid  (o_mv[g]),
            .m_axis_tdata   (o_md[g]),
            .m_axis_tkeep   (o_mk[g]),
            .m_axis_tlast   (o_ml[g]),
            .m_axis_tuser   (o_mu[g])
`ifdef ETH_TX_ARB_STATS_EN
            ,
            .stat_frames0   (o_f0[g]),
            .stat_frames1   (o_f1[g]),
            .stat_err       (o_err[g])
`endif
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference model: owner=-1 means no open frame; cool counts pacing cycles left.
    int m_owner [3];
    int m_cool  [3];
    int m_grant [3];
    int m_last  [3];
    int m_frames[3];
    int m_f0    [3];
    int m_f1    [3];
    int m_err   [3];

    function automatic int gap_of(input int d);
        return (d == 2) ? 12 : 0;
    endfunction

    function automatic bit prio_of(input int d);
        return (d == 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1; m_cool[d] = 0; m_grant[d] = 0; m_last[d] = 1;
            m_frames[d] = 0; m_f0[d] = 0; m_f1[d] = 0; m_err[d] = 0;
        end
    endtask

    task automatic model_check(input int d);
        int own;
        int pick;
        logic emv, eml, emu, er0, er1;
        logic [63:0] emd;
        logic [7:0] emk, edbg;
        logic [1:0] st;
        own = m_owner[d];
        emv = 1'b0; emd = 64'd0; emk = 8'd0; eml = 1'b0; emu = 1'b0; er0 = 1'b0; er1 = 1'b0;
        if (own >= 0) begin
            emv = s_v[own];
            if (emv) begin
                emd = s_d[own]; emk = s_k[own]; eml = s_l[own]; emu = s_u[own];
            end
            er0 = (own == 0) && m_ready;
            er1 = (own == 1) && m_ready;
        end
        st = (own >= 0) ? 2'b01 : ((m_cool[d] > 0) ? 2'b10 : 2'b00);
        edbg = {st, 1'(m_grant[d]), 1'(m_last[d]), 4'(m_frames[d] % 16)};
        chk($sformatf("d%0d_tvalid", d), 64'(o_mv[d]), 64'(emv));
        chk($sformatf("d%0d_tdata", d), o_md[d], emd);
        chk($sformatf("d%0d_tkeep", d), 64'(o_mk[d]), 64'(emk));
        chk($sformatf("d%0d_tlast", d), 64'(o_ml[d]), 64'(eml));
        chk($sformatf("d%0d_tuser", d), 64'(o_mu[d]), 64'(emu));
        chk($sformatf("d%0d_s0_tready", d), 64'(o_r0[d]), 64'(er0));
        chk($sformatf("d%0d_s1_tready", d), 64'(o_r1[d]), 64'(er1));
        chk($sformatf("d%0d_debug", d), 64'(o_dbg[d]), 64'(edbg));
`ifdef ETH_TX_ARB_STATS_EN
        chk($sformatf("d%0d_stat_frames0", d), 64'(o_f0[d]), 64'(32'(m_f0[d])));
        chk($sformatf("d%0d_stat_frames1", d), 64'(o_f1[d]), 64'(32'(m_f1[d])));
        chk($sformatf("d%0d_stat_err", d), 64'(o_err[d]), 64'(16'(m_err[d])));
`endif
        if (own >= 0) begin
            if (s_v[own] && m_ready && s_l[own]) begin
                m_last[d] = own;
                m_frames[d]++;
                if (own == 0) m_f0[d]++; else m_f1[d]++;
                if (s_u[own] && m_err[d] < 65535) m_err[d]++;
                m_owner[d] = -1;
                m_cool[d] = gap_of(d);
            end
        end else if (m_cool[d] > 0) begin
            m_cool[d]--;
        end else if (s_v[0] || s_v[1]) begin
            if (s_v[0] && s_v[1]) pick = prio_of(d) ? 1 : 1 - m_last[d];
            else pick = s_v[1] ? 1 : 0;
            m_owner[d] = pick;
            m_grant[d] = pick;
        end
    endtask

    // Frame sources; they follow the tready of instance 'fol'.
    int  fol = 0;
    bit  en [2];
    int  beat [2];
    int  fr [2];
    int  nb [2];
    int  stall_left [2];
    bit  stall_en, stall_done, tog_ready, err_en;
    bit  hs [2];
    int  order_q [$];
    int  beat_q [$];
    int  gap_meas_q [$];
    bit  gap_armed;
    int  gap_idle;

    task automatic src_reset();
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; beat[p] = 0; fr[p] = 0; nb[p] = 2; stall_left[p] = 0; hs[p] = 1'b0;
            s_v[p] = 1'b0; s_d[p] = 64'd0; s_k[p] = 8'd0; s_l[p] = 1'b0; s_u[p] = 1'b0;
        end
        stall_en = 1'b0; stall_done = 1'b0; tog_ready = 1'b0; err_en = 1'b0;
        m_ready = 1'b1;
        order_q.delete(); beat_q.delete(); gap_meas_q.delete();
        gap_armed = 1'b0; gap_idle = 0;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < 2; p++) begin
            s_v[p] = (stall_left[p] > 0) ? 1'b0 : en[p];
            s_d[p] = {8'(p), 24'(fr[p]), 32'(beat[p])};
            s_l[p] = (beat[p] == nb[p] - 1);
            s_k[p] = s_l[p] ? 8'h0f : 8'hff;
            s_u[p] = err_en && s_l[p] && ((fr[p] % 2) == 0);
        end
        m_ready = tog_ready ? ~m_ready : 1'b1;
    endtask

    task automatic step_sample();
        @(negedge clk156);
        hs[0] = s_v[0] && o_r0[fol];
        hs[1] = s_v[1] && o_r1[fol];
        if (o_mv[fol] && m_ready) begin
            if (o_md[fol][63:56] == 8'd1) beat_q.push_back(int'(o_md[fol][31:0]));
            if (gap_armed && o_md[fol][31:0] == 32'd0) begin
                gap_meas_q.push_back(gap_idle);
                gap_armed = 1'b0;
            end
            if (o_ml[fol]) begin
                order_q.push_back(int'(o_md[fol][63:56]));
                gap_armed = 1'b1;
                gap_idle = 0;
            end
        end else if (gap_armed && !o_mv[fol]) begin
            gap_idle++;
        end
        for (int d = 0; d < 3; d++) model_check(d);
    endtask

    task automatic step_advance();
        @(posedge clk156);
        #1;
    endtask

    task automatic src_cycle();
        drive_inputs();
        step_sample();
        step_advance();
        for (int p = 0; p < 2; p++) begin
            if (stall_left[p] > 0) begin
                stall_left[p]--;
            end else if (hs[p]) begin
                if (beat[p] == nb[p] - 1) begin
                    beat[p] = 0;
                    fr[p]++;
                end else begin
                    beat[p]++;
                end
            end
        end
        if (stall_en && !stall_done && beat[1] == 2) begin
            stall_left[1] = 5;
            stall_done = 1'b1;
        end
    endtask

    task automatic run_until(input string name, input int n_frames, input int budget);
        int c = 0;
        while (order_q.size() < n_frames && c < budget) begin
            src_cycle();
            c++;
        end
        chk({name, "_frames_done"}, 64'(order_q.size()), 64'(n_frames));
    endtask

    task automatic do_reset();
        eth_rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_d%0d_outputs", d),
                {o_md[d][31:0] | o_md[d][63:32], o_mk[d], o_dbg[d], 13'd0, o_mv[d], o_ml[d], o_mu[d]},
                64'd0);
            chk($sformatf("rst_d%0d_treadys", d), {62'd0, o_r0[d], o_r1[d]}, 64'd0);
        end
        repeat (2) @(posedge clk156);
        #1;
        src_reset();
        eth_rst = 1'b0;
        model_reset();
        @(negedge clk156);
        for (int d = 0; d < 3; d++) chk($sformatf("post_rst_d%0d_debug", d), 64'(o_dbg[d]), 64'h10);
        step_advance();
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        rdy;
        logic        emv;
        logic [63:0] emd;
        logic [7:0]  emk;
        logic        eml;
        logic        er0;
    } vec_t;

    vec_t tbl [5];
    int   r0_bad;
    int   c;

    initial begin
        src_reset();
        model_reset();
        tbl[0] = '{1'b1, 64'h1, 8'hff, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 64'h1, 8'hff, 1'b0, 1'b1, 1'b1, 64'h1, 8'hff, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 64'h2, 8'hff, 1'b0, 1'b1, 1'b1, 64'h2, 8'hff, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 64'h3, 8'h0f, 1'b1, 1'b1, 1'b1, 64'h3, 8'h0f, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0};
        repeat (2) @(posedge clk156);
        #1;
        do_reset();

        // Single source, 3-beat frame on port 0.
        for (int i = 0; i < 5; i++) begin
            s_v[0] = tbl[i].v; s_d[0] = tbl[i].d; s_k[0] = tbl[i].k; s_l[0] = tbl[i].l;
            s_u[0] = 1'b0; s_v[1] = 1'b0; m_ready = tbl[i].rdy;
            step_sample();
            chk($sformatf("tbl%0d_tvalid", i), 64'(o_mv[0]), 64'(tbl[i].emv));
            chk($sformatf("tbl%0d_tdata", i), o_md[0], tbl[i].emd);
            chk($sformatf("tbl%0d_tkeep", i), 64'(o_mk[0]), 64'(tbl[i].emk));
            chk($sformatf("tbl%0d_tlast", i), 64'(o_ml[0]), 64'(tbl[i].eml));
            chk($sformatf("tbl%0d_s0_tready", i), 64'(o_r0[0]), 64'(tbl[i].er0));
            step_advance();
        end

        // Round-robin contention: 2-beat frames from both ports.
        do_reset();
        fol = 0; en[0] = 1'b1; en[1] = 1'b1;
        run_until("rr", 4, 40);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), 64'(order_q.size() > i ? order_q[i] : -1), 64'(i % 2));
        chk("rr_frame_cnt", 64'(o_dbg[0][3:0]), 64'd4);

        // Fixed priority: port 1 monopolises while valid, then port 0 gets through.
        do_reset();
        fol = 1; en[0] = 1'b1; en[1] = 1'b1;
        run_until("fp_hi", 4, 40);
        en[1] = 1'b0;
        run_until("fp_lo", 5, 40);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fp_order%0d", i), 64'(order_q.size() > i ? order_q[i] : -1), 64'(i < 4 ? 1 : 0));

        // Backpressure toggling plus a 5-cycle source stall mid-frame on port 1.
        do_reset();
        fol = 0; nb[1] = 6; en[1] = 1'b1; stall_en = 1'b1; tog_ready = 1'b1; m_ready = 1'b0;
        src_cycle();
        en[0] = 1'b1;
        r0_bad = 0;
        c = 0;
        while (fr[1] == 0 && c < 80) begin
            if (o_r0[0]) r0_bad++;
            src_cycle();
            c++;
        end
        chk("stall_frame_done", 64'(fr[1]), 64'd1);
        chk("stall_s0_tready_low", 64'(r0_bad), 64'd0);
        chk("stall_beats", 64'(beat_q.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("stall_beat%0d", i), 64'(beat_q.size() > i ? beat_q[i] : -1), 64'(i));
        en[0] = 1'b0; en[1] = 1'b0; tog_ready = 1'b0;
        repeat (5) src_cycle();

        // Pacing: back-to-back frames through the GAP_CYCLES=12 instance, two with tuser set.
        do_reset();
        fol = 2; en[0] = 1'b1; err_en = 1'b1;
        run_until("gap", 4, 200);
        chk("gap_count", 64'(gap_meas_q.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("gap_idle%0d", i), 64'(gap_meas_q.size() > i ? gap_meas_q[i] : -1), 64'd13);
`ifdef ETH_TX_ARB_STATS_EN
        chk("gap_stat_frames0", 64'(o_f0[2]), 64'd4);
        chk("gap_stat_frames1", 64'(o_f1[2]), 64'd0);
        chk("gap_stat_err", 64'(o_err[2]), 64'd2);
`endif

        // Random traffic against the model, with a reset dropped in mid-run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            for (int p = 0; p < 2; p++) begin
                s_v[p] = ($urandom_range(0, 3) != 0);
                s_d[p] = {$urandom(), $urandom()};
                s_k[p] = 8'($urandom());
                s_l[p] = ($urandom_range(0, 3) == 0);
                s_u[p] = ($urandom_range(0, 1) == 1);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            step_sample();
            step_advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
